// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pins plus local tx/rx word handshake for one spi_slave instance.
interface spi_slave_if #(
  parameter int WIDTH = 8
);
  logic             SCLK;
  logic             CS;
  logic             MOSI;
  logic             MISO;
  logic [WIDTH-1:0] slaveDataToSend;
  logic             txLoad;
  logic [WIDTH-1:0] slaveDataReceived;
  logic             dataValid;
  logic             frameAbort;
  logic             busy;

  modport slave (
    input  SCLK, CS, MOSI, slaveDataToSend, txLoad,
    output MISO, slaveDataReceived, dataValid, frameAbort, busy
  );

  modport master (
    output SCLK, CS, MOSI, slaveDataToSend, txLoad,
    input  MISO, slaveDataReceived, dataValid, frameAbort, busy
  );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled LSB-first SPI slave endpoint; SPI_SLAVE_MISO_TRISTATE_EN floats MISO while idle.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       reset,
  spi_slave_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic [WIDTH-1:0]       tx_hold_q, tx_hold_d;
  logic [WIDTH-1:0]       tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   miso_q, miso_d;
  logic                   data_valid_q, data_valid_d;
  logic                   frame_abort_q, frame_abort_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      tx_hold_q     <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      bit_cnt_q     <= '0;
      miso_q        <= 1'b0;
      data_valid_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
      cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], bus.CS};
      mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
      sclk_prev_q   <= sclk_s;
      cs_prev_q     <= cs_s;
      tx_hold_q     <= tx_hold_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      bit_cnt_q     <= bit_cnt_d;
      miso_q        <= miso_d;
      data_valid_q  <= data_valid_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tx_hold_d     = bus.txLoad ? bus.slaveDataToSend : tx_hold_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    bit_cnt_d     = bit_cnt_q;
    data_valid_d  = 1'b0;
    frame_abort_d = 1'b0;
    // MISO trails the shift register by one cycle, so HOLD keeps the last bit.
    miso_d        = (state_q == IDLE) ? 1'b0 : tx_shift_q[0];

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          tx_shift_d = bus.txLoad ? bus.slaveDataToSend : tx_hold_q;
          bit_cnt_d  = '0;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          frame_abort_d = 1'b1;
          state_d       = IDLE;
        end else if (sclk_fall) begin
          rx_shift_d = {mosi_s, rx_shift_q[WIDTH-1:1]};
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
        end else if (sclk_rise && bit_cnt_q != '0) begin
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      DONE: begin
        rx_data_d    = rx_shift_q;
        data_valid_d = 1'b1;
        state_d      = cs_rise ? IDLE : HOLD;
      end
      HOLD: begin
        if (cs_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign bus.MISO = (state_q == IDLE) ? 1'bz : miso_q;
`else
  assign bus.MISO = miso_q;
`endif
  assign bus.slaveDataReceived = rx_data_q;
  assign bus.dataValid         = data_valid_q;
  assign bus.frameAbort        = frame_abort_q;
  assign bus.busy              = (state_q != IDLE);
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed and random SPI frames against a word-level slave model.
module tb_spi_slave;
  localparam int W    = 8;
  localparam int HALF = 6;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  localparam logic IDLE_MISO = 1'bz;
`else
  localparam logic IDLE_MISO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_slave_if #(.WIDTH(W)) bus ();
  spi_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int dv_pulses = 0, dv_cycles = 0, fa_pulses = 0, fa_cycles = 0;
  logic dv_prev = 1'b0, fa_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.dataValid === 1'b1) begin
      dv_cycles <= dv_cycles + 1;
      if (!dv_prev) dv_pulses <= dv_pulses + 1;
    end
    if (bus.frameAbort === 1'b1) begin
      fa_cycles <= fa_cycles + 1;
      if (!fa_prev) fa_pulses <= fa_pulses + 1;
    end
    dv_prev <= (bus.dataValid === 1'b1);
    fa_prev <= (bus.frameAbort === 1'b1);
  end

  // word-level model: what the slave should send and what it last delivered
  logic [W-1:0] m_hold, m_rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] v);
    @(negedge clk);
    bus.slaveDataToSend = v;
    bus.txLoad = 1'b1;
    @(negedge clk);
    bus.txLoad = 1'b0;
    m_hold = v;
  endtask

  task automatic run_frame(input logic [W-1:0] mw, input int nf, input int extra,
                           input bit lc, input logic [W-1:0] lcv,
                           input bit lm, input logic [W-1:0] lmv,
                           input logic exp_last,
                           output logic [W-1:0] sw, output logic busy_mid,
                           output logic stable);
    sw = '0;
    busy_mid = 1'b0;
    stable = 1'b1;
    @(negedge clk);
    bus.CS = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (lc) begin
      bus.slaveDataToSend = lcv;
      bus.txLoad = 1'b1;
    end
    @(negedge clk);
    bus.txLoad = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nf; i++) begin
      bus.MOSI = mw[i];
      bus.SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      sw[i] = bus.MISO;
      bus.SCLK = 1'b0;
      for (int c = 0; c < HALF; c++) begin
        @(negedge clk);
        if (lm && i == 2 && c == 0) begin
          bus.slaveDataToSend = lmv;
          bus.txLoad = 1'b1;
        end else begin
          bus.txLoad = 1'b0;
        end
      end
      if (i == 0) busy_mid = bus.busy;
    end
    for (int e = 0; e < extra; e++) begin
      bus.SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      if (bus.MISO !== exp_last) stable = 1'b0;
      bus.SCLK = 1'b0;
      repeat (HALF) @(negedge clk);
      if (bus.MISO !== exp_last) stable = 1'b0;
    end
    bus.CS = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic frame_and_check(input string tag, input logic [W-1:0] mw, input int nf,
                                 input int extra, input bit lc, input logic [W-1:0] lcv,
                                 input bit lm, input logic [W-1:0] lmv);
    logic [W-1:0] exp_tx, sw;
    logic [8:0]   mask;
    logic         busy_mid, stable;
    int           dv0, dc0, fa0, fc0;
    exp_tx = lc ? lcv : m_hold;
    mask   = (9'd1 << nf) - 9'd1;
    dv0 = dv_pulses; dc0 = dv_cycles; fa0 = fa_pulses; fc0 = fa_cycles;
    run_frame(mw, nf, extra, lc, lcv, lm, lmv, exp_tx[W-1], sw, busy_mid, stable);
    if (lc) m_hold = lcv;
    if (lm) m_hold = lmv;
    if (nf == W) m_rx = mw;
    chk({tag, "_miso_word"}, sw, exp_tx & mask[W-1:0]);
    chk({tag, "_rx_word"}, bus.slaveDataReceived, m_rx);
    chk({tag, "_dv_pulses"}, dv_pulses - dv0, (nf == W) ? 1 : 0);
    chk({tag, "_dv_cycles"}, dv_cycles - dc0, (nf == W) ? 1 : 0);
    chk({tag, "_fa_pulses"}, fa_pulses - fa0, (nf == W) ? 0 : 1);
    chk({tag, "_fa_cycles"}, fa_cycles - fc0, (nf == W) ? 0 : 1);
    chk({tag, "_busy_mid"}, busy_mid, 1);
    chk({tag, "_busy_after"}, bus.busy, 0);
    if (extra > 0) chk({tag, "_miso_stable"}, stable, 1);
  endtask

  initial begin
    int dv0, fa0;
    logic [W-1:0] rv, rm;
    bus.SCLK = 1'b0;
    bus.CS = 1'b1;
    bus.MOSI = 1'b0;
    bus.txLoad = 1'b0;
    bus.slaveDataToSend = '0;
    m_hold = '0;
    m_rx = '0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dv", bus.dataValid, 0);
    chk("rst_fa", bus.frameAbort, 0);
    chk("rst_rx", bus.slaveDataReceived, 0);
    chk("rst_miso", {31'b0, bus.MISO}, {31'b0, IDLE_MISO});
    reset = 1'b0;
    repeat (3) @(negedge clk);

    load(8'hA5);
    frame_and_check("basic", 8'h3C, W, 0, 0, 8'h00, 0, 8'h00);
    frame_and_check("abort5", 8'h96, 5, 0, 0, 8'h00, 0, 8'h00);
    frame_and_check("midload", 8'h11, W, 0, 0, 8'h00, 1, 8'h5A);
    frame_and_check("afterload", 8'hE7, W, 0, 0, 8'h00, 0, 8'h00);
    frame_and_check("csload", 8'h42, W, 0, 1, 8'h81, 0, 8'h00);
    frame_and_check("extra", 8'hC3, W, 3, 0, 8'h00, 0, 8'h00);

    // reset in the middle of a frame: no pulses, everything back to reset values
    dv0 = dv_pulses;
    fa0 = fa_pulses;
    @(negedge clk);
    bus.CS = 1'b0;
    repeat (HALF + 3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.MOSI = 1'b1;
      bus.SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.SCLK = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_rx", bus.slaveDataReceived, 0);
    chk("midrst_miso", {31'b0, bus.MISO}, {31'b0, IDLE_MISO});
    bus.CS = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    m_hold = '0;
    m_rx = '0;
    repeat (6) @(negedge clk);
    chk("midrst_no_dv", dv_pulses - dv0, 0);
    chk("midrst_no_fa", fa_pulses - fa0, 0);
    frame_and_check("postrst", 8'hFF, W, 0, 0, 8'h00, 0, 8'h00);

    for (int r = 0; r < 6; r++) begin
      rv = W'($urandom);
      rm = W'($urandom);
      if (r % 2 == 0) load(rv);
      frame_and_check("rand", rm, W, 0, 0, 8'h00, 0, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
